// File: rtl/exec_unit_arbiter.sv
// exec_unit_arbiter
//   Shares one combinational Execution_Unit between two requesters
//   (requester 0 = fetch/PC-adder path, requester 1 = EX path).
//   Each requester offers an op over a valid/ready channel. A round-robin grant
//   picks one op, the op is driven to the Execution_Unit for one cycle, and the
//   EU result plus zero/negative flags are registered onto a single response
//   channel tagged with the requester id. Only one op is in flight at a time.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake for requester N (0/1)
//   reqN_a, reqN_b                operands
//   reqN_op, reqN_shamt           EU opcode and shift amount
//   rsp_valid / rsp_ready         response handshake
//   rsp_id                        requester that issued the op
//   rsp_result, rsp_zero, rsp_neg registered EU outputs
//   eu_operand_a/_b, eu_opcode,
//   eu_shift_amount               drive the Execution_Unit inputs
//   eu_result, eu_zero, eu_neg    Execution_Unit outputs
//
// Optional feature (macro EXEC_ARB_PERF_EN)
//   Adds saturating 32-bit counters perf_grant0, perf_grant1 (grants per
//   requester) and perf_stall (RESP cycles with rsp_ready low). Without the
//   macro these ports do not exist and behaviour is otherwise identical.

module exec_unit_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [OP_W-1:0]    req0_op,
  input  logic [SHAMT_W-1:0] req0_shamt,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [OP_W-1:0]    req1_op,
  input  logic [SHAMT_W-1:0] req1_shamt,

  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_zero,
  output logic               rsp_neg,

  output logic [DATA_W-1:0]  eu_operand_a,
  output logic [DATA_W-1:0]  eu_operand_b,
  output logic [OP_W-1:0]    eu_opcode,
  output logic [SHAMT_W-1:0] eu_shift_amount,
  input  logic [DATA_W-1:0]  eu_result,
  input  logic               eu_zero,
  input  logic               eu_neg
`ifdef EXEC_ARB_PERF_EN
  ,
  output logic [31:0]        perf_grant0,
  output logic [31:0]        perf_grant1,
  output logic [31:0]        perf_stall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic               last_grant;
  logic               grant_any;
  logic               grant_id;
  logic               grant_fire;
  logic               issue_done;
  logic               rsp_fire;

  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [OP_W-1:0]    sel_op;
  logic [SHAMT_W-1:0] sel_shamt;

  logic               iss_id_p0;
  logic [DATA_W-1:0]  iss_a_p0;
  logic [DATA_W-1:0]  iss_b_p0;
  logic [OP_W-1:0]    iss_op_p0;
  logic [SHAMT_W-1:0] iss_shamt_p0;

  logic               vld_p1;
  logic               rsp_id_p1;
  logic [DATA_W-1:0]  rsp_result_p1;
  logic               rsp_zero_p1;
  logic               rsp_neg_p1;

  // Round-robin: with both requesting, the one not granted last time wins.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  assign sel_a     = grant_id ? req1_a     : req0_a;
  assign sel_b     = grant_id ? req1_b     : req0_b;
  assign sel_op    = grant_id ? req1_op    : req0_op;
  assign sel_shamt = grant_id ? req1_shamt : req0_shamt;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. The grant is masked while rst is high: a reset edge never
  // accepts an op, so no requester may see ready on it.
  always_comb begin
    grant_fire = 1'b0;
    issue_done = 1'b0;
    rsp_fire   = 1'b0;
    case (state_q)
      ST_IDLE:  grant_fire = grant_any && !rst;
      ST_ISSUE: issue_done = 1'b1;
      ST_RESP:  rsp_fire   = rsp_ready;
      default:  ;
    endcase
  end

  assign req0_ready = grant_fire && !grant_id;
  assign req1_ready = grant_fire &&  grant_id;

  // ---- stage p0: issue registers, held through ISSUE and RESP ----
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      iss_id_p0    <= 1'b0;
      iss_a_p0     <= '0;
      iss_b_p0     <= '0;
      iss_op_p0    <= '0;
      iss_shamt_p0 <= '0;
    end else if (grant_fire) begin
      last_grant   <= grant_id;
      iss_id_p0    <= grant_id;
      iss_a_p0     <= sel_a;
      iss_b_p0     <= sel_b;
      iss_op_p0    <= sel_op;
      iss_shamt_p0 <= sel_shamt;
    end
  end

  assign eu_operand_a    = iss_a_p0;
  assign eu_operand_b    = iss_b_p0;
  assign eu_opcode       = iss_op_p0;
  assign eu_shift_amount = iss_shamt_p0;

  // ---- stage p1: response registers, captured at the end of ISSUE ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      rsp_id_p1     <= 1'b0;
      rsp_result_p1 <= '0;
      rsp_zero_p1   <= 1'b0;
      rsp_neg_p1    <= 1'b0;
    end else if (issue_done) begin
      vld_p1        <= 1'b1;
      rsp_id_p1     <= iss_id_p0;
      rsp_result_p1 <= eu_result;
      rsp_zero_p1   <= eu_zero;
      rsp_neg_p1    <= eu_neg;
    end else if (rsp_fire) begin
      vld_p1        <= 1'b0;
    end
  end

  assign rsp_valid  = vld_p1;
  assign rsp_id     = rsp_id_p1;
  assign rsp_result = rsp_result_p1;
  assign rsp_zero   = rsp_zero_p1;
  assign rsp_neg    = rsp_neg_p1;

`ifdef EXEC_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic [31:0] grant0_cnt;
  logic [31:0] grant1_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (req0_ready) grant0_cnt <= sat_inc(grant0_cnt);
      if (req1_ready) grant1_cnt <= sat_inc(grant1_cnt);
      if (state_q == ST_RESP && !rsp_ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign perf_grant0 = grant0_cnt;
  assign perf_grant1 = grant1_cnt;
  assign perf_stall  = stall_cnt;
`endif

endmodule

// File: tb/tb_exec_unit_arbiter.sv
// Testbench for exec_unit_arbiter: a behavioural Execution_Unit drives the
// eu_* return path, a transaction-level model predicts every output each
// cycle, and directed sequences pin the model with literal expectations.
module tb_exec_unit_arbiter;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]    req0_op, req1_op;
  logic [SHAMT_W-1:0] req0_shamt, req1_shamt;
  logic               rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg;
  logic [DATA_W-1:0]  rsp_result;
  logic [DATA_W-1:0]  eu_operand_a, eu_operand_b, eu_result;
  logic [OP_W-1:0]    eu_opcode;
  logic [SHAMT_W-1:0] eu_shift_amount;
  logic               eu_zero, eu_neg;
`ifdef EXEC_ARB_PERF_EN
  logic [31:0]        perf_grant0, perf_grant1, perf_stall;
`endif

  exec_unit_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .eu_operand_a(eu_operand_a), .eu_operand_b(eu_operand_b), .eu_opcode(eu_opcode),
    .eu_shift_amount(eu_shift_amount), .eu_result(eu_result), .eu_zero(eu_zero), .eu_neg(eu_neg)
`ifdef EXEC_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  // Behavioural Execution_Unit
  function automatic logic [DATA_W-1:0] eu_fn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [OP_W-1:0] op, input logic [SHAMT_W-1:0] sh);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return DATA_W'($signed(a) >>> sh);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  assign eu_result = eu_fn(eu_operand_a, eu_operand_b, eu_opcode, eu_shift_amount);
  assign eu_zero   = (eu_result == '0);
  assign eu_neg    = eu_result[DATA_W-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase counts where the single in-flight op is: 0 none, 1 at the EU,
  // 2 waiting for the consumer.
  bit                 model_on = 1'b0;
  int                 m_phase  = 0;
  bit                 m_last   = 1'b1;
  bit                 m_fresh  = 1'b1;
  bit                 m_id     = 1'b0;
  logic [DATA_W-1:0]  m_a = '0, m_b = '0;
  logic [OP_W-1:0]    m_op = '0;
  logic [SHAMT_W-1:0] m_sh = '0;
  longint             m_pg0 = 0, m_pg1 = 0, m_stall = 0;

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  always @(negedge clk) begin
    bit any, gid;
    logic [DATA_W-1:0] er;
    if (rst) begin
      model_on = 1'b1;
      chk("rst_ready0", 64'(req0_ready), 64'(0));
      chk("rst_ready1", 64'(req1_ready), 64'(0));
      m_phase = 0; m_last = 1'b1; m_fresh = 1'b1; m_id = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_sh = '0;
      m_pg0 = 0; m_pg1 = 0; m_stall = 0;
    end else if (model_on) begin
      any = (m_phase == 0) && (req0_valid || req1_valid);
      gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
      chk("ready0", 64'(req0_ready), 64'(any && !gid));
      chk("ready1", 64'(req1_ready), 64'(any && gid));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase != 0 || m_fresh) begin
        chk("eu_a", 64'(eu_operand_a), 64'(m_a));
        chk("eu_b", 64'(eu_operand_b), 64'(m_b));
        chk("eu_op", 64'(eu_opcode), 64'(m_op));
        chk("eu_sh", 64'(eu_shift_amount), 64'(m_sh));
      end
      if (m_phase == 2) begin
        er = eu_fn(m_a, m_b, m_op, m_sh);
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_result", 64'(rsp_result), 64'(er));
        chk("rsp_zero", 64'(rsp_zero), 64'(er == '0));
        chk("rsp_neg", 64'(rsp_neg), 64'(er[DATA_W-1]));
      end else if (m_fresh) begin
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(0));
        chk("rst_rsp_flags", 64'({rsp_zero, rsp_neg}), 64'(0));
      end
`ifdef EXEC_ARB_PERF_EN
      chk("perf_grant0", 64'(perf_grant0), 64'(sat32(m_pg0)));
      chk("perf_grant1", 64'(perf_grant1), 64'(sat32(m_pg1)));
      chk("perf_stall", 64'(perf_stall), 64'(sat32(m_stall)));
`endif
      // what the coming edge does
      if (any) begin
        m_last = gid; m_id = gid; m_fresh = 1'b0; m_phase = 1;
        if (gid) begin
          m_a = req1_a; m_b = req1_b; m_op = req1_op; m_sh = req1_shamt; m_pg1++;
        end else begin
          m_a = req0_a; m_b = req0_b; m_op = req0_op; m_sh = req0_shamt; m_pg0++;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (rsp_ready) m_phase = 0;
        else m_stall++;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit s0, s1;

  // Sample the ready lines at mid-cycle, then move to just after the next edge.
  task automatic step();
    @(negedge clk);
    s0 = req0_ready;
    s1 = req1_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
  endfunction

  task automatic new0();
    req0_a = rnd_data(); req0_b = rnd_data();
    req0_op = OP_W'($urandom_range(0, 15)); req0_shamt = SHAMT_W'($urandom);
  endtask

  task automatic new1();
    req1_a = rnd_data(); req1_b = rnd_data();
    req1_op = OP_W'($urandom_range(0, 15)); req1_shamt = SHAMT_W'($urandom);
  endtask

  // Single op from one requester with literal expected response; entered and
  // left just after a clock edge with the arbiter idle and rsp_ready high.
  task automatic direct(input string name, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [4:0] sh,
                        input logic [31:0] er, input bit ez, input bit en);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_shamt = sh;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_shamt = sh;
    end
    @(negedge clk);
    chk({name, "_ready"}, 64'(id ? req1_ready : req0_ready), 64'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1_valid"}, 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({name, "_id"}, 64'(rsp_id), 64'(id));
    chk({name, "_result"}, 64'(rsp_result), 64'(er));
    chk({name, "_zero"}, 64'(rsp_zero), 64'(ez));
    chk({name, "_neg"}, 64'(rsp_neg), 64'(en));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, ngr;
    bit gseq [4];
    int gcyc [4];
    bit h_id, h_z, h_n;
    logic [DATA_W-1:0] h_res;

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req0_shamt = '0;
    req1_a = '0; req1_b = '0; req1_op = '0; req1_shamt = '0;

    // reset for two edges, then idle with no requests
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t1_rsp_result", 64'(rsp_result), 64'(0));
    chk("t1_eu_a", 64'(eu_operand_a), 64'(0));
    chk("t1_ready", 64'({req0_ready, req1_ready}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t1_idle_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t1_idle_ready", 64'({req0_ready, req1_ready}), 64'(0));
    end
    @(posedge clk); #1;

    // both requesters always valid: four grants alternating, 3 cycles apart
    req0_valid = 1'b1; new0();
    req1_valid = 1'b1; new1();
    ngr = 0; guard = 0;
    while (ngr < 4 && guard < 40) begin
      step();
      guard++;
      chk("t3_double_grant", 64'(s0 && s1), 64'(0));
      if (s0 || s1) begin
        gseq[ngr] = s1;
        gcyc[ngr] = guard;
        ngr++;
        if (s0) new0();
        if (s1) new1();
      end
    end
    chk("t3_grant_count", 64'(ngr), 64'(4));
    chk("t3_grant_seq", 64'({gseq[0], gseq[1], gseq[2], gseq[3]}), 64'(4'b0101));
    chk("t3_interval1", 64'(gcyc[1] - gcyc[0]), 64'(3));
    chk("t3_interval3", 64'(gcyc[3] - gcyc[2]), 64'(3));

    // backpressure: rsp_ready low for the 5 RESP cycles of the fourth op
    rsp_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("t4_ready_low", 64'({req0_ready, req1_ready}), 64'(0));
      if (k == 0) begin
        h_id = rsp_id; h_res = rsp_result; h_z = rsp_zero; h_n = rsp_neg;
        chk("t4_id", 64'(rsp_id), 64'(1));
      end else begin
        chk("t4_stable", 64'({rsp_id, rsp_zero, rsp_neg, rsp_result}), 64'({h_id, h_z, h_n, h_res}));
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_valid", 64'(rsp_valid), 64'(1));
`ifdef EXEC_ARB_PERF_EN
    chk("t6_perf_grant0", 64'(perf_grant0), 64'(2));
    chk("t6_perf_grant1", 64'(perf_grant1), 64'(2));
    chk("t6_perf_stall", 64'(perf_stall), 64'(5));
`endif
    @(posedge clk); #1;
    step();
    chk("t4_regrant_next", 64'(s0 || s1), 64'(1));

    // reset during ISSUE: op discarded, no response, round-robin restarts at 0
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; new0();
    req1_valid = 1'b1; new1();
    step();
    chk("t5_last_grant", 64'({s0, s1}), 64'(2'b10));
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step(); step();

    // single-op latency and literal results
    direct("t2_add", 1'b0, 32'h5, 32'h7, 4'h0, 5'd0, 32'hC, 1'b0, 1'b0);
    direct("t2_zero", 1'b1, 32'h3, 32'h3, 4'h1, 5'd0, 32'h0, 1'b1, 1'b0);
    direct("t2_neg", 1'b0, 32'h0, 32'h1, 4'h1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    direct("t2_sra", 1'b1, 32'h8000_0000, 32'h0, 4'h7, 5'd4, 32'hF800_0000, 1'b0, 1'b1);

    // randomized traffic with backpressure, withdrawn requests and resets
    for (int c = 0; c < 2500; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (s0 || !req0_valid) begin
        req0_valid = $urandom_range(0, 1) == 1; new0();
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (s1 || !req1_valid) begin
        req1_valid = $urandom_range(0, 1) == 1; new1();
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
